// File: rtl/cmem_loader_if.sv
// Stream-in / context-memory-write bundle for the CGRA context memory loader.
// The master side is the loader: it consumes the stream and drives the memory write bus.
interface cmem_loader_if #(
    parameter int unsigned N_ROW             = 4,
    parameter int unsigned IMEM_N_LINES_LOG2 = 5,
    parameter int unsigned DATA_WIDTH        = 32
);
    logic                         s_valid_i;
    logic [DATA_WIDTH-1:0]        s_data_i;
    logic                         s_ready_o;
    logic [N_ROW-1:0]             cm_row_req_o;
    logic                         cm_we_o;
    logic [IMEM_N_LINES_LOG2-1:0] cm_addr_o;
    logic [DATA_WIDTH-1:0]        cm_wdata_o;

    modport master (
        input  s_valid_i, s_data_i,
        output s_ready_o, cm_row_req_o, cm_we_o, cm_addr_o, cm_wdata_o
    );

    modport slave (
        output s_valid_i, s_data_i,
        input  s_ready_o, cm_row_req_o, cm_we_o, cm_addr_o, cm_wdata_o
    );
endinterface

// File: rtl/cmem_loader.sv
// Sequences a kernel image word stream into per-row context memory writes,
// either row by row over the selected rows or broadcast to all of them at once.
module cmem_loader #(
    parameter int unsigned N_ROW             = 4,
    parameter int unsigned IMEM_N_LINES_LOG2 = 5,
    parameter int unsigned DATA_WIDTH        = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [N_ROW-1:0]               row_mask_i,
    input  logic                           broadcast_i,
    input  logic [IMEM_N_LINES_LOG2-1:0]   base_addr_i,
    input  logic [IMEM_N_LINES_LOG2:0]     n_words_i,
    input  logic                           abort_i,
    cmem_loader_if.master                  bus,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);
    localparam int unsigned AW    = IMEM_N_LINES_LOG2;
    localparam int unsigned NW    = IMEM_N_LINES_LOG2 + 1;
    localparam int unsigned SW    = IMEM_N_LINES_LOG2 + 2;
    localparam int unsigned DEPTH = 2 ** IMEM_N_LINES_LOG2;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [N_ROW-1:0]       mask_q, mask_d;
    logic                   bcast_q, bcast_d;
    logic [AW-1:0]          base_q, base_d;
    logic [NW-1:0]          nwords_q, nwords_d;
    logic [N_ROW-1:0]       row_q, row_d;
    logic [NW-1:0]          cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [N_ROW-1:0]       req_q, req_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   ready_c;
    logic                   hs_c;
    logic [NW-1:0]          cnt_inc_c;
    logic [N_ROW-1:0]       higher_c;
    logic [N_ROW-1:0]       first_row_c;
    logic [SW-1:0]          end_line_c;
    logic                   cmd_ok_c;

    // Abort wins over a same-cycle handshake by withholding ready.
    assign ready_c = (state_q == LOAD) && !abort_i;
    assign hs_c    = bus.s_valid_i && ready_c;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        bcast_d  = bcast_q;
        base_d   = base_q;
        nwords_d = nwords_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        req_d    = '0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        cnt_inc_c   = cnt_q + NW'(1);
        // Selected rows strictly above the current one-hot row pointer.
        higher_c    = mask_q & ~(row_q | (row_q - N_ROW'(1)));
        first_row_c = row_mask_i & (~row_mask_i + N_ROW'(1));
        end_line_c  = SW'(base_addr_i) + SW'(n_words_i);
        cmd_ok_c    = (row_mask_i != '0) && (n_words_i != '0) && (end_line_c <= SW'(DEPTH));

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (cmd_ok_c) begin
                        mask_d   = row_mask_i;
                        bcast_d  = broadcast_i;
                        base_d   = base_addr_i;
                        nwords_d = n_words_i;
                        row_d    = broadcast_i ? row_mask_i : first_row_c;
                        cnt_d    = '0;
                        state_d  = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (hs_c) begin
                    we_d    = 1'b1;
                    req_d   = row_q;
                    addr_d  = base_q + AW'(cnt_q);
                    wdata_d = bus.s_data_i;
                    if (cnt_inc_c == nwords_q) begin
                        cnt_d = '0;
                        if (bcast_q || (higher_c == '0)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            row_d = higher_c & (~higher_c + N_ROW'(1));
                        end
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
            end
        endcase

        busy_d = (state_d == LOAD) || done_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            bcast_q  <= 1'b0;
            base_q   <= '0;
            nwords_q <= '0;
            row_q    <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            req_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            bcast_q  <= bcast_d;
            base_q   <= base_d;
            nwords_q <= nwords_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.s_ready_o    = ready_c;
    assign bus.cm_we_o      = we_q;
    assign bus.cm_row_req_o = req_q;
    assign bus.cm_addr_o    = addr_q;
    assign bus.cm_wdata_o   = wdata_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
endmodule

// File: tb/tb_cmem_loader.sv
// Randomized bench for cmem_loader: expected write sequences come from a
// row/word enumeration of each command, compared with writes seen on the bus.
module tb_cmem_loader;
    localparam int unsigned N_ROW = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic [N_ROW-1:0]  row_mask_i = '0;
    logic              broadcast_i = 1'b0;
    logic [AW-1:0]     base_addr_i = '0;
    logic [AW:0]       n_words_i = '0;
    logic              abort_i = 1'b0;
    logic              busy_o, done_o, err_o;

    cmem_loader_if #(.N_ROW(N_ROW), .IMEM_N_LINES_LOG2(AW), .DATA_WIDTH(DW)) bus ();

    cmem_loader #(.N_ROW(N_ROW), .IMEM_N_LINES_LOG2(AW), .DATA_WIDTH(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .row_mask_i  (row_mask_i),
        .broadcast_i (broadcast_i),
        .base_addr_i (base_addr_i),
        .n_words_i   (n_words_i),
        .abort_i     (abort_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_ROW-1:0] row;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    data;
    } wr_t;

    wr_t         obs[$];
    wr_t         exp_q[$];
    logic [DW-1:0] words[128];
    int          n_done = 0, n_err = 0, n_busy = 0, bad_we = 0, bad_busy = 0;
    logic        prev_hs = 1'b0, prev_done = 1'b0, seen_rst = 1'b0;
    int          nchk = 0, npass = 0;
    logic [45:0] snap;

    // Bus monitor: records every presented write and protocol-level anomalies.
    always @(negedge clk) begin
        wr_t w;
        if (seen_rst) begin
            if (bus.cm_we_o) begin
                w = {bus.cm_row_req_o, bus.cm_addr_o, bus.cm_wdata_o};
                obs.push_back(w);
            end
            if (done_o) n_done++;
            if (err_o) n_err++;
            if (busy_o) n_busy++;
            if (bus.cm_we_o !== prev_hs || (!bus.cm_we_o && bus.cm_row_req_o !== '0)) bad_we++;
            if ((done_o && (!busy_o || !bus.cm_we_o)) || (prev_done && busy_o)) bad_busy++;
        end
        if (rst_i) seen_rst = 1'b1;
        prev_hs   = bus.s_valid_i && bus.s_ready_o && !rst_i;
        prev_done = done_o;
    end

    function automatic void fill_words(input bit ramp);
        for (int i = 0; i < 128; i++) words[i] = ramp ? DW'(i) : DW'($urandom);
    endfunction

    // Reference: rows ascending, n words each, or one pass to the whole mask.
    function automatic void build_exp(input logic [N_ROW-1:0] mask, input logic bc,
                                      input logic [AW-1:0] base, input logic [AW:0] n,
                                      input int limit);
        int  k = 0;
        wr_t w;
        exp_q.delete();
        for (int r = 0; r < int'(N_ROW); r++) begin
            if (bc && r > 0) break;
            if (!bc && !mask[r]) continue;
            for (int i = 0; i < int'(n); i++) begin
                w.row  = bc ? mask : (N_ROW'(1) << r);
                w.addr = AW'(int'(base) + i);
                w.data = words[k];
                k++;
                exp_q.push_back(w);
            end
        end
        while (limit >= 0 && exp_q.size() > limit) void'(exp_q.pop_back());
    endfunction

    function automatic int first_diff(input int o0);
        int n = obs.size() - o0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= n || obs[o0 + i] !== exp_q[i]) return i;
        if (n != exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    task automatic run_load(input logic [N_ROW-1:0] mask, input logic bc,
                            input logic [AW-1:0] base, input logic [AW:0] n,
                            input int mode, input int stop_at, input bit use_rst,
                            input bit poke, output int acc, output int cyc,
                            output logic rdy_stop);
        int total;
        bit stop;
        total    = bc ? int'(n) : int'(n) * $countones(mask);
        acc      = 0;
        cyc      = 0;
        rdy_stop = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1; row_mask_i = mask; broadcast_i = bc; base_addr_i = base; n_words_i = n;
        @(posedge clk); #1;
        start_i = 1'b0;
        forever begin
            bus.s_valid_i = (mode == 0) ? 1'b1 :
                            (mode == 1) ? 1'((cyc % 3) == 0) : 1'($urandom_range(0, 1));
            bus.s_data_i  = words[acc];
            abort_i       = !use_rst && (acc == stop_at);
            rst_i         = use_rst && (acc == stop_at);
            start_i       = poke && (cyc == 1);
            if (poke && cyc == 1) row_mask_i = '0;
            @(negedge clk);
            stop = (acc == stop_at);
            if (stop) rdy_stop = bus.s_ready_o;
            if (bus.s_valid_i && bus.s_ready_o && !stop) begin
                acc++;
                if (acc == total) stop = 1'b1;
            end
            cyc++;
            @(posedge clk); #1;
            if (stop) break;
            if (cyc > 1000) begin
                nchk++;
                $display("FAIL load_timeout: got %0d handshakes, required %0d", acc, total);
                break;
            end
        end
        bus.s_valid_i = 1'b0; abort_i = 1'b0; rst_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        snap = {bus.cm_we_o, bus.cm_row_req_o, bus.cm_addr_o, bus.cm_wdata_o,
                busy_o, done_o, err_o, bus.s_ready_o};
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nchk++;
        if ({bus.cm_we_o, bus.cm_row_req_o, bus.cm_addr_o, bus.cm_wdata_o, busy_o, done_o, err_o,
             bus.s_ready_o} !== 46'd0)
            $display("FAIL reset_outputs: got we=%b req=%b addr=%0d data=%h busy=%b done=%b err=%b rdy=%b, required all 0",
                     bus.cm_we_o, bus.cm_row_req_o, bus.cm_addr_o, bus.cm_wdata_o, busy_o, done_o, err_o, bus.s_ready_o);
        else npass++;
        @(posedge clk); #1;
        rst_i   = 1'b0;
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        @(negedge clk);
        nchk++;
        if ({busy_o, err_o, bus.s_ready_o, bus.cm_we_o} !== 4'b0000)
            $display("FAIL idle_abort: got busy=%b err=%b rdy=%b we=%b, required 0000", busy_o, err_o, bus.s_ready_o, bus.cm_we_o);
        else npass++;
    endtask

    task automatic test_broadcast();
        int o0 = obs.size(), d0 = n_done, b0 = bad_busy, w0 = bad_we, acc, cyc, d;
        logic r;
        fill_words(1'b1);
        run_load(4'b1111, 1'b1, 5'd0, 6'd32, 0, -1, 1'b0, 1'b0, acc, cyc, r);
        build_exp(4'b1111, 1'b1, 5'd0, 6'd32, -1);
        nchk++; if (obs.size() - o0 !== 32) $display("FAIL bcast_count: got %0d writes, required 32", obs.size() - o0); else npass++;
        d = first_diff(o0);
        nchk++; if (d != -1) $display("FAIL bcast_data: write %0d got %h required %h", d, obs[o0 + d], exp_q[d]); else npass++;
        nchk++; if (n_done - d0 !== 1) $display("FAIL bcast_done: got %0d pulses, required 1", n_done - d0); else npass++;
        nchk++; if (cyc !== 32) $display("FAIL bcast_cycles: got %0d cycles, required 32", cyc); else npass++;
        nchk++; if (bad_busy - b0 + bad_we - w0 !== 0) $display("FAIL bcast_timing: got %0d busy/done and %0d we anomalies, required 0", bad_busy - b0, bad_we - w0); else npass++;
    endtask

    task automatic test_sparse(input int mode, input string nm);
        int o0 = obs.size(), d0 = n_done, w0 = bad_we, acc, cyc, d;
        logic r;
        fill_words(1'b0);
        run_load(4'b1010, 1'b0, 5'd5, 6'd3, mode, -1, 1'b0, 1'b0, acc, cyc, r);
        build_exp(4'b1010, 1'b0, 5'd5, 6'd3, -1);
        d = first_diff(o0);
        nchk++; if (d != -1) $display("FAIL %s_data: write %0d got %h required %h (writes %0d/6)", nm, d, obs[o0 + d], exp_q[d], obs.size() - o0); else npass++;
        nchk++; if (n_done - d0 !== 1) $display("FAIL %s_done: got %0d pulses, required 1", nm, n_done - d0); else npass++;
        nchk++; if (bad_we - w0 !== 0) $display("FAIL %s_we: got %0d cycles with we not following handshake, required 0", nm, bad_we - w0); else npass++;
    endtask

    task automatic test_illegal();
        logic [N_ROW-1:0] m[3] = '{4'b0101, 4'b0000, 4'b0011};
        logic [AW-1:0]    b[3] = '{5'd30, 5'd0, 5'd3};
        logic [AW:0]      n[3] = '{6'd3, 6'd4, 6'd0};
        int o0 = obs.size(), e0 = n_err, y0 = n_busy;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            start_i = 1'b1; row_mask_i = m[k]; broadcast_i = 1'(k == 1); base_addr_i = b[k]; n_words_i = n[k];
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            nchk++;
            if (err_o !== 1'b1 || busy_o !== 1'b0)
                $display("FAIL illegal_%0d: got err=%b busy=%b, required err=1 busy=0", k, err_o, busy_o);
            else npass++;
            repeat (2) @(posedge clk);
        end
        @(negedge clk);
        nchk++;
        if (obs.size() - o0 !== 0 || n_err - e0 !== 3 || n_busy - y0 !== 0)
            $display("FAIL illegal_side: got writes=%0d errs=%0d busy_cycles=%0d, required 0/3/0", obs.size() - o0, n_err - e0, n_busy - y0);
        else npass++;
    endtask

    task automatic test_exact_end();
        int o0 = obs.size(), d0 = n_done, e0 = n_err, acc, cyc, d;
        logic r;
        fill_words(1'b0);
        run_load(4'b0100, 1'b0, 5'd30, 6'd2, 0, -1, 1'b0, 1'b0, acc, cyc, r);
        build_exp(4'b0100, 1'b0, 5'd30, 6'd2, -1);
        d = first_diff(o0);
        nchk++; if (d != -1 || n_err - e0 !== 0) $display("FAIL exact_end: write %0d got %h required %h, errs %0d", d, obs[o0 + d], exp_q[d], n_err - e0); else npass++;
        nchk++; if (n_done - d0 !== 1) $display("FAIL exact_end_done: got %0d pulses, required 1", n_done - d0); else npass++;
    endtask

    task automatic test_abort();
        int o0 = obs.size(), d0 = n_done, acc, cyc, d;
        logic r;
        fill_words(1'b0);
        run_load(4'b0001, 1'b0, 5'd4, 6'd8, 0, 2, 1'b0, 1'b0, acc, cyc, r);
        build_exp(4'b0001, 1'b0, 5'd4, 6'd8, 2);
        d = first_diff(o0);
        nchk++; if (d != -1) $display("FAIL abort_writes: write %0d got %h required %h (writes %0d/2)", d, obs[o0 + d], exp_q[d], obs.size() - o0); else npass++;
        nchk++; if (r !== 1'b0) $display("FAIL abort_ready: got s_ready=%b during abort, required 0", r); else npass++;
        nchk++; if (n_done - d0 !== 0 || busy_o !== 1'b0) $display("FAIL abort_state: got done=%0d busy=%b, required 0/0", n_done - d0, busy_o); else npass++;
        o0 = obs.size(); d0 = n_done;
        fill_words(1'b0);
        run_load(4'b0110, 1'b0, 5'd10, 6'd4, 2, -1, 1'b0, 1'b0, acc, cyc, r);
        build_exp(4'b0110, 1'b0, 5'd10, 6'd4, -1);
        d = first_diff(o0);
        nchk++; if (d != -1 || n_done - d0 !== 1) $display("FAIL abort_next: write %0d got %h required %h, done %0d", d, obs[o0 + d], exp_q[d], n_done - d0); else npass++;
    endtask

    task automatic test_reset_mid_load();
        int o0 = obs.size(), d0 = n_done, acc, cyc, d;
        logic r;
        fill_words(1'b0);
        run_load(4'b1111, 1'b0, 5'd0, 6'd5, 0, 3, 1'b1, 1'b0, acc, cyc, r);
        build_exp(4'b1111, 1'b0, 5'd0, 6'd5, 3);
        nchk++; if (snap !== 46'd0) $display("FAIL rst_mid_outputs: got %h, required 0", snap); else npass++;
        d = first_diff(o0);
        nchk++; if (d != -1 || n_done - d0 !== 0) $display("FAIL rst_mid_writes: write %0d got %h required %h, done %0d", d, obs[o0 + d], exp_q[d], n_done - d0); else npass++;
        o0 = obs.size(); d0 = n_done;
        fill_words(1'b0);
        run_load(4'b0011, 1'b1, 5'd20, 6'd6, 1, -1, 1'b0, 1'b0, acc, cyc, r);
        build_exp(4'b0011, 1'b1, 5'd20, 6'd6, -1);
        d = first_diff(o0);
        nchk++; if (d != -1 || n_done - d0 !== 1) $display("FAIL rst_mid_fresh: write %0d got %h required %h, done %0d", d, obs[o0 + d], exp_q[d], n_done - d0); else npass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int o0 = obs.size(), d0 = n_done, e0 = n_err, b0 = bad_busy, w0 = bad_we, acc, cyc, d;
            logic r;
            logic [N_ROW-1:0] m  = N_ROW'($urandom_range(1, 15));
            logic             bc = 1'($urandom_range(0, 1));
            logic [AW:0]      n  = (AW + 1)'($urandom_range(1, 32));
            logic [AW-1:0]    b  = AW'($urandom_range(0, 32 - int'(n)));
            int               md = int'($urandom_range(0, 2));
            bit               pk = 1'($urandom_range(0, 1));
            fill_words(1'b0);
            run_load(m, bc, b, n, md, -1, 1'b0, pk, acc, cyc, r);
            build_exp(m, bc, b, n, -1);
            d = first_diff(o0);
            nchk++;
            if (d != -1)
                $display("FAIL rand%0d_data: m=%b bc=%b base=%0d n=%0d write %0d got %h required %h", it, m, bc, b, n, d, obs[o0 + d], exp_q[d]);
            else npass++;
            nchk++;
            if (n_done - d0 !== 1 || n_err - e0 !== 0 || bad_busy - b0 !== 0 || bad_we - w0 !== 0)
                $display("FAIL rand%0d_ctrl: got done=%0d err=%0d busy_anom=%0d we_anom=%0d, required 1/0/0/0", it, n_done - d0, n_err - e0, bad_busy - b0, bad_we - w0);
            else npass++;
        end
    endtask

    initial begin
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        test_reset();
        test_broadcast();
        test_sparse(0, "sparse");
        test_sparse(1, "gaps");
        test_illegal();
        test_exact_end();
        test_abort();
        test_reset_mid_load();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1);
    end
endmodule

// File: doc/cmem_loader.md
Name: cmem_loader

Overview:
- Bus-side writer for the CGRA per-row context memories. It is the producer of the row-request/write-enable/address/data interface that the context memory instances consume.
- Accepts a kernel image as a valid/ready word stream and sequences it into context memory writes, row by row or broadcast to all selected rows.
- Sits between the CGRA peripheral/DMA slave port and the context memory block.
- Holds busy_o high while loading so the controller does not launch kernels.

Parameters:
- N_ROW, 4, number of context memories (one per CGRA row)
- IMEM_N_LINES_LOG2, 5, context memory address width; depth = 2**IMEM_N_LINES_LOG2
- DATA_WIDTH, 32, stream and context memory word width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  load command strobe, sampled only in IDLE
- row_mask_i  in  N_ROW  rows to load, sampled with start_i
- broadcast_i  in  1  1: each word is written to all masked rows at once; sampled with start_i
- base_addr_i  in  IMEM_N_LINES_LOG2  first line to write, sampled with start_i
- n_words_i  in  IMEM_N_LINES_LOG2+1  words per row, sampled with start_i
- abort_i  in  1  cancel the load in progress
- s_valid_i  in  1  stream word valid
- s_data_i  in  DATA_WIDTH  stream word
- s_ready_o  out  1  stream ready
- cm_row_req_o  out  N_ROW  per-row memory request
- cm_we_o  out  1  write enable
- cm_addr_o  out  IMEM_N_LINES_LOG2  write address
- cm_wdata_o  out  DATA_WIDTH  write data
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle pulse on completion
- err_o  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset: state IDLE. All outputs 0. Counters, row pointer and latched command are cleared.
- States: IDLE, LOAD.
- Command check in IDLE when start_i=1:
  - Rejected if row_mask_i==0, or n_words_i==0, or base_addr_i+n_words_i > 2**IMEM_N_LINES_LOG2. The sum is computed at IMEM_N_LINES_LOG2+2 bits, so there is no wrap-around.
  - Rejected command: err_o pulses on the next cycle, no writes are issued, state stays IDLE.
  - Accepted command: the command is latched and state goes to LOAD on the next cycle.
- Row pointer on entering LOAD:
  - Non-broadcast: the lowest set bit of the mask.
  - Broadcast: the whole mask, and only one pass is made.
  - Word counter starts at 0.
- In LOAD, s_ready_o=1 combinationally. s_ready_o is 0 in IDLE and on the cycle the final write is presented.
- Handshake: s_valid_i & s_ready_o on cycle N produces, on cycle N+1 (registered outputs):
  - cm_we_o=1
  - cm_row_req_o = one-hot current row (non-broadcast) or the latched mask (broadcast)
  - cm_addr_o = base + word counter
  - cm_wdata_o = s_data_i
- Cycles without a handshake: cm_we_o=0 and cm_row_req_o=0 on the next cycle; addr and data hold their previous values.
- Counter advance after each handshake:
  - Word counter increments.
  - When it reaches n_words, it resets to 0 and the row pointer moves to the next higher set bit of the mask.
  - If there is no higher set bit, or in broadcast mode, that handshake is the last one.
- Last handshake: state goes to IDLE. done_o pulses in the same cycle the final write is presented.
- busy_o = (state==LOAD) or (final write being presented), so it deasserts the cycle after done_o.
- abort_i in LOAD:
  - A handshake in the same cycle is not accepted: abort takes priority and s_ready_o is forced to 0.
  - Next cycle: state IDLE, no write, no done_o.
  - Writes already presented remain in memory.
  - abort_i in IDLE is ignored.
- start_i while in LOAD is ignored, with no err_o.
- Reset mid-load: the next cycle shows reset values; a pending write is dropped.
- Total handshakes: n_words × popcount(mask) (non-broadcast), or n_words (broadcast).

Test Plan:
- Broadcast fill: start with mask=4'b1111, broadcast=1, base=0, n_words=32, stream 0..31 with s_valid_i held high.
  - Expect 32 writes with cm_row_req_o=4'b1111 and addr=data=0..31.
  - done_o pulses on the cycle of the 32nd write; busy_o falls the following cycle.
- Sparse per-row: mask=4'b1010, base=5, n_words=3, data A0..A5.
  - Expect row_req 4'b0010 at addr 5,6,7 with data A0..A2, then row_req 4'b1000 at addr 5,6,7 with data A3..A5.
  - Exactly 6 writes, then done_o.
- Backpressure gaps: same as the previous test with s_valid_i toggling 1,0,0,1,...
  - cm_we_o is 0 on each cycle following a gap.
  - Address and data sequence unchanged; no duplicate writes.
- Bounds and illegal commands, each giving an err_o pulse, no writes and busy_o staying 0:
  - base=30, n_words=3
  - mask=0
  - n_words=0
- Exact end: base=30, n_words=2 is accepted and writes addr 30 and 31.
- Abort: abort_i after 2 of 8 handshakes, with s_valid_i high.
  - The third word is not accepted and no third write appears.
  - No done_o; state returns to IDLE.
  - A following start runs normally.
- Reset mid-load: rst_i asserted during LOAD, then a new command issued.
  - All outputs are 0 the next cycle.
  - The new command behaves as a fresh load.
